// File: rtl/sram_like_arbiter.sv
// Two-master arbiter (data port has priority over instruction port) in front of one
// SRAM-like port; an in-order tag FIFO routes each data_ok back to its requester.
module sram_like_arbiter #(
  parameter int OUTSTANDING = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [3:0]  inst_wstrb,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata,
  output logic        resp_err
);

  localparam int CW = $clog2(OUTSTANDING + 1);
  localparam int PW = $clog2(OUTSTANDING);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] LOCK_I = 2'd1;
  localparam logic [1:0] LOCK_D = 2'd2;

  logic [1:0]    state;
  logic [CW-1:0] count;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          tags [OUTSTANDING];

  logic full;
  logic grant_i;
  logic grant_d;
  logic accept;
  logic resp;
  logic head_tag;

  assign full     = (count == CW'(OUTSTANDING));
  assign head_tag = tags[rd_ptr];

  // A lock holds the grant regardless of FIFO state: its slot was reserved when it was taken.
  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (!reset) begin
      case (state)
        IDLE: begin
          if (!full && data_req)      grant_d = 1'b1;
          else if (!full && inst_req) grant_i = 1'b1;
        end
        LOCK_I:  grant_i = 1'b1;
        LOCK_D:  grant_d = 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    mem_req   = grant_i | grant_d;
    mem_wr    = 1'b0;
    mem_size  = 2'd0;
    mem_addr  = 32'd0;
    mem_wstrb = 4'd0;
    mem_wdata = 32'd0;
    if (grant_d) begin
      mem_wr    = data_wr;
      mem_size  = data_size;
      mem_addr  = data_addr;
      mem_wstrb = data_wstrb;
      mem_wdata = data_wdata;
    end else if (grant_i) begin
      mem_wr    = inst_wr;
      mem_size  = inst_size;
      mem_addr  = inst_addr;
      mem_wstrb = inst_wstrb;
      mem_wdata = inst_wdata;
    end
  end

  assign accept       = mem_req & mem_addr_ok;
  assign inst_addr_ok = accept & grant_i;
  assign data_addr_ok = accept & grant_d;

  assign resp         = !reset && mem_data_ok && (count != '0);
  assign inst_data_ok = resp & !head_tag;
  assign data_data_ok = resp & head_tag;
  assign inst_rdata   = reset ? 32'd0 : mem_rdata;
  assign data_rdata   = reset ? 32'd0 : mem_rdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      resp_err <= 1'b0;
      for (int i = 0; i < OUTSTANDING; i++) tags[i] <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_d && !mem_addr_ok)      state <= LOCK_D;
          else if (grant_i && !mem_addr_ok) state <= LOCK_I;
        end
        LOCK_I, LOCK_D: if (mem_addr_ok) state <= IDLE;
        default: state <= IDLE;
      endcase

      if (accept) begin
        tags[wr_ptr] <= grant_d;
        wr_ptr       <= wr_ptr + PW'(1);
      end
      if (resp) rd_ptr <= rd_ptr + PW'(1);

      if (accept && !resp)      count <= count + CW'(1);
      else if (!accept && resp) count <= count - CW'(1);

      if (mem_data_ok && count == '0) resp_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Table-driven bench for sram_like_arbiter; a tag scoreboard predicts which master
// each mem_data_ok must be routed to.
module tb_sram_like_arbiter;

  localparam logic [31:0] IADDR = 32'h1c00_0000;
  localparam logic [31:0] DADDR = 32'h8000_1000;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_req, inst_wr, data_req, data_wr;
  logic [1:0]  inst_size, data_size, mem_size;
  logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
  logic [3:0]  inst_wstrb, data_wstrb, mem_wstrb;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata;
  logic        mem_req, mem_wr, mem_addr_ok, mem_data_ok, resp_err;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int checks = 0;
  int fails  = 0;

  typedef struct {
    logic        ireq, dreq, aok, dok;
    logic [31:0] rdata;
    logic        mreq, own_d, iaok, daok, err;
  } vec_t;

  vec_t vq[$];
  bit   sb_q[$];

  sram_like_arbiter #(.OUTSTANDING(4)) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
    .inst_wstrb(inst_wstrb), .inst_wdata(inst_wdata), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wstrb(data_wstrb), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_addr(mem_addr),
    .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok),
    .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata), .resp_err(resp_err)
  );

  always #5 clk = ~clk;

  task automatic check1(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add_vec(input logic ireq, input logic dreq, input logic aok, input logic dok,
                         input logic [31:0] rdata, input logic mreq, input logic own_d,
                         input logic iaok, input logic daok, input logic err);
    vec_t v;
    v.ireq = ireq; v.dreq = dreq; v.aok = aok; v.dok = dok; v.rdata = rdata;
    v.mreq = mreq; v.own_d = own_d; v.iaok = iaok; v.daok = daok; v.err = err;
    vq.push_back(v);
  endtask

  task automatic check_output(input vec_t v);
    bit own;
    check1("mem_req", {31'd0, mem_req}, {31'd0, v.mreq});
    if (v.mreq) begin
      check1("mem_addr", mem_addr, v.own_d ? DADDR : IADDR);
      check1("mem_wr", {31'd0, mem_wr}, {31'd0, v.own_d});
    end
    check1("inst_addr_ok", {31'd0, inst_addr_ok}, {31'd0, v.iaok});
    check1("data_addr_ok", {31'd0, data_addr_ok}, {31'd0, v.daok});
    check1("resp_err", {31'd0, resp_err}, {31'd0, v.err});
    if (v.dok && sb_q.size() != 0) begin
      own = sb_q.pop_front();
      check1("inst_data_ok", {31'd0, inst_data_ok}, {31'd0, !own});
      check1("data_data_ok", {31'd0, data_data_ok}, {31'd0, own});
      check1("rdata", own ? data_rdata : inst_rdata, v.rdata);
    end else begin
      check1("inst_data_ok", {31'd0, inst_data_ok}, 32'd0);
      check1("data_data_ok", {31'd0, data_data_ok}, 32'd0);
    end
    if (v.iaok) sb_q.push_back(1'b0);
    if (v.daok) sb_q.push_back(1'b1);
  endtask

  task automatic apply_stimulus(input vec_t v);
    @(negedge clk);
    inst_req    = v.ireq;
    data_req    = v.dreq;
    mem_addr_ok = v.aok;
    mem_data_ok = v.dok;
    mem_rdata   = v.rdata;
    #1;
    check_output(v);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; inst_req = 1'b1; data_req = 1'b1;
    mem_addr_ok = 1'b1; mem_data_ok = 1'b1; mem_rdata = 32'hCAFE_F00D;
    #1;
    check1("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check1("rst_addr_ok", {30'd0, inst_addr_ok, data_addr_ok}, 32'd0);
    check1("rst_data_ok", {30'd0, inst_data_ok, data_data_ok}, 32'd0);
    check1("rst_rdata", inst_rdata | data_rdata, 32'd0);
    @(negedge clk);
    reset = 1'b0; inst_req = 1'b0; data_req = 1'b0;
    mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = 32'd0;
    #1;
    check1("post_rst_mem_req", {31'd0, mem_req}, 32'd0);
    check1("post_rst_resp_err", {31'd0, resp_err}, 32'd0);
    sb_q.delete();
  endtask

  initial begin
    reset = 1'b1;
    inst_req = 1'b0; inst_wr = 1'b0; inst_size = 2'd2; inst_addr = IADDR;
    inst_wstrb = 4'h0; inst_wdata = 32'h0;
    data_req = 1'b0; data_wr = 1'b1; data_size = 2'd2; data_addr = DADDR;
    data_wstrb = 4'hF; data_wdata = 32'h1234_5678;
    mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = 32'd0;

    // ireq dreq aok dok rdata | mreq own_d iaok daok err
    add_vec(1,0,1,0,32'h0,         1,0,1,0,0);
    add_vec(0,0,0,0,32'h0,         0,0,0,0,0);
    add_vec(0,0,0,1,32'hDEADBEEF,  0,0,0,0,0);
    add_vec(1,1,1,0,32'h0,         1,1,0,1,0);
    add_vec(1,0,1,0,32'h0,         1,0,1,0,0);
    add_vec(0,0,0,1,32'h1111_1111, 0,0,0,0,0);
    add_vec(0,0,0,1,32'h2222_2222, 0,0,0,0,0);
    add_vec(0,1,1,0,32'h0,         1,1,0,1,0);
    add_vec(1,0,1,1,32'h3333_3333, 1,0,1,0,0);
    add_vec(0,0,0,1,32'h4444_4444, 0,0,0,0,0);
    add_vec(1,0,0,0,32'h0,         1,0,0,0,0);
    add_vec(1,1,0,0,32'h0,         1,0,0,0,0);
    add_vec(1,1,0,0,32'h0,         1,0,0,0,0);
    add_vec(1,1,1,0,32'h0,         1,0,1,0,0);
    add_vec(0,1,1,0,32'h0,         1,1,0,1,0);
    add_vec(0,0,0,1,32'h5555_5555, 0,0,0,0,0);
    add_vec(0,0,0,1,32'h6666_6666, 0,0,0,0,0);
    add_vec(0,1,1,0,32'h0,         1,1,0,1,0);
    add_vec(1,0,1,0,32'h0,         1,0,1,0,0);
    add_vec(0,1,1,0,32'h0,         1,1,0,1,0);
    add_vec(1,0,1,0,32'h0,         1,0,1,0,0);
    add_vec(1,1,1,0,32'h0,         0,0,0,0,0);
    add_vec(1,0,1,1,32'h70,        0,0,0,0,0);
    add_vec(1,0,1,0,32'h0,         1,0,1,0,0);
    add_vec(0,0,0,1,32'h71,        0,0,0,0,0);
    add_vec(0,0,0,1,32'h72,        0,0,0,0,0);
    add_vec(0,0,0,1,32'h73,        0,0,0,0,0);
    add_vec(0,0,0,1,32'h74,        0,0,0,0,0);
    add_vec(0,0,0,1,32'hBAD,       0,0,0,0,0);
    add_vec(0,0,0,0,32'h0,         0,0,0,0,1);
    add_vec(1,0,1,0,32'h0,         1,0,1,0,1);
    add_vec(0,0,0,1,32'h75,        0,0,0,0,1);

    do_reset();
    foreach (vq[i]) apply_stimulus(vq[i]);
    check1("sb_drained", sb_q.size(), 32'd0);

    // Error flag survives until reset and is then cleared.
    do_reset();

    // Reset with two transactions in flight, then a stale response.
    vq.delete();
    add_vec(0,1,1,0,32'h0, 1,1,0,1,0);
    add_vec(1,0,1,0,32'h0, 1,0,1,0,0);
    foreach (vq[i]) apply_stimulus(vq[i]);
    do_reset();
    @(negedge clk);
    mem_data_ok = 1'b1; mem_rdata = 32'h5A5A_5A5A;
    #1;
    check1("stale_data_ok", {30'd0, inst_data_ok, data_data_ok}, 32'd0);
    @(negedge clk);
    mem_data_ok = 1'b0;
    #1;
    check1("stale_resp_err", {31'd0, resp_err}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
